// File: rtl/waterfall_line_writer.sv
// Averages DECIM ADC samples per pixel into a line buffer, then copies each full
// line into the frame RAM during lower blanking and advances the waterfall row pointer.
module waterfall_line_writer #(
  parameter int LINE_W = 320,
  parameter int ROWS   = 240,
  parameter int DECIM  = 4,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sample_valid,
  input  logic [11:0]       sample_data,
  input  logic              blank,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic [7:0]        scroll_row,
  output logic              line_done,
  output logic [7:0]        overrun_cnt
);

  localparam int SH = $clog2(DECIM);
  localparam int AW = 12 + SH;
  localparam int DW = (SH == 0) ? 1 : SH;
  localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {FILL, WAIT_BLANK, WRITE} state_t;

  state_t            state;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     sum;
  logic [DW-1:0]     dcnt;
  logic [CW-1:0]     col;
  logic [CW-1:0]     wcol;
  logic [RW-1:0]     wr_row;
  logic [RW-1:0]     next_row;
  logic [ADDR_W-1:0] row_base;
  logic [7:0]        pixel;
  logic              last_sample;
  logic              pix_store;
  logic [7:0]        linebuf [LINE_W];

  // Average is sum >> SH; the 8-bit pixel is bits [11:4] of that average.
  assign sum         = acc + AW'(sample_data);
  assign pixel       = sum[SH+4 +: 8];
  assign last_sample = (dcnt == DW'(DECIM - 1));
  assign pix_store   = (state == FILL) && sample_valid && last_sample;
  assign next_row    = (wr_row == RW'(ROWS - 1)) ? '0 : wr_row + RW'(1);

  // NOTE: the line buffer is plain storage with no reset so it maps onto RAM;
  // its contents are always written before they are read.
  always_ff @(posedge clk) begin
    if (pix_store) linebuf[col] <= pixel;
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= FILL;
      acc         <= '0;
      dcnt        <= '0;
      col         <= '0;
      wcol        <= '0;
      wr_row      <= '0;
      row_base    <= '0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      scroll_row  <= '0;
      line_done   <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      ram_we    <= 1'b0;
      line_done <= 1'b0;

      // Samples arriving while a finished line waits for / is being written are lost.
      if (sample_valid && state != FILL && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        FILL: begin
          if (sample_valid) begin
            if (last_sample) begin
              acc  <= '0;
              dcnt <= '0;
              if (col == CW'(LINE_W - 1)) begin
                col   <= '0;
                state <= WAIT_BLANK;
              end else begin
                col <= col + CW'(1);
              end
            end else begin
              acc  <= sum;
              dcnt <= dcnt + DW'(1);
            end
          end
        end

        WAIT_BLANK: begin
          if (blank) begin
            wcol  <= '0;
            state <= WRITE;
          end
        end

        WRITE: begin
          if (blank) begin
            ram_we    <= 1'b1;
            ram_addr  <= row_base + ADDR_W'(wcol);
            ram_wdata <= linebuf[wcol];
            if (wcol == CW'(LINE_W - 1)) begin
              wcol       <= '0;
              wr_row     <= next_row;
              row_base   <= (next_row == '0) ? '0 : row_base + ADDR_W'(LINE_W);
              scroll_row <= 8'(next_row);
              line_done  <= 1'b1;
              state      <= FILL;
            end else begin
              wcol <= wcol + CW'(1);
            end
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule
